// File: rtl/adder32_rr_sched.sv
// -----------------------------------------------------------------------------
// adder32_rr_sched
//   Round-robin scheduler sharing one combinational 32-bit carry-lookahead
//   adder among NREQ requesters. One request is granted per cycle. Its result
//   lands in a single-entry output register tagged with the requester ID.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  [NREQ]     per-requester valid
//   req_ready  [NREQ]     per-requester accept (one-hot or zero), combinational
//   req_a/b    [32*NREQ]  operands, requester i at bits [32*i+31:32*i]
//   req_cin    [NREQ]     carry-in for add (ignored for subtract)
//   req_sub    [NREQ]     1 = A-B, 0 = A+B+cin
//   rsp_valid  result valid
//   rsp_ready  consumer accepts result
//   rsp_id     [IDW]      owner of the result
//   rsp_sum    [32]       low 32 bits of the result
//   rsp_cout   carry out of bit 31 (subtract: 1 = no borrow)
//   rsp_ovf    signed overflow
// -----------------------------------------------------------------------------

// 32-bit carry-lookahead adder: 4-bit lookahead groups, with group
// generate/propagate chained across the eight groups.
module adder32_cla (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [31:0] w_c;
  logic [8:0]  w_gc;

  assign w_g     = i_a & i_b;
  assign w_p     = i_a ^ i_b;
  assign w_gc[0] = i_cin;

  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    localparam int B = 4 * gi;
    logic w_grp_g;
    logic w_grp_p;

    assign w_c[B]   = w_gc[gi];
    assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[gi]);
    assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) |
                      (w_p[B+1] & w_p[B] & w_gc[gi]);
    assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) |
                      (w_p[B+2] & w_p[B+1] & w_g[B]) |
                      (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[gi]);

    assign w_grp_g = w_g[B+3] | (w_p[B+3] & w_g[B+2]) |
                     (w_p[B+3] & w_p[B+2] & w_g[B+1]) |
                     (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
    assign w_grp_p = &w_p[B+3:B];
    assign w_gc[gi+1] = w_grp_g | (w_grp_p & w_gc[gi]);
  end

  assign o_sum  = w_p ^ w_c;
  assign o_cout = w_gc[8];
endmodule

module adder32_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
  input  logic [NREQ-1:0]      req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_ovf
);
  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [31:0]    r_sum;
  logic           r_cout;
  logic           r_ovf;

  logic           w_found;
  logic [IDW-1:0] w_grant;
  logic [IDW:0]   w_cand;
  logic           w_can_accept;
  logic           w_xfer;

  logic [31:0]    w_a;
  logic [31:0]    w_b;
  logic [31:0]    w_bb;
  logic           w_c0;
  logic [31:0]    w_sum;
  logic           w_cout;
  logic           w_ovf;

  // Rotating priority search starting at r_ptr. The candidate index is kept
  // one bit wider so the wrap can be done by a single conditional subtract,
  // which also skips nonexistent indices when NREQ is not a power of two.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_cand >= NREQ_W) begin
        w_cand = w_cand - NREQ_W;
      end
      if (!w_found && req_valid[w_cand[IDW-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_cand[IDW-1:0];
      end
    end
  end

  assign w_can_accept = (r_state == ST_EMPTY) | rsp_ready;
  // rst is folded in so req_ready reads zero for the whole reset window,
  // not just after the next edge.
  assign w_xfer = w_found & w_can_accept & ~rst;

  always_comb begin
    req_ready = '0;
    if (w_xfer) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  // Operand select and subtract-as-add-of-complement.
  assign w_a  = req_a[32*w_grant +: 32];
  assign w_b  = req_b[32*w_grant +: 32];
  assign w_bb = req_sub[w_grant] ? ~w_b : w_b;
  assign w_c0 = req_sub[w_grant] ? 1'b1 : req_cin[w_grant];

  adder32_cla u_adder (
    .i_a    (w_a),
    .i_b    (w_bb),
    .i_cin  (w_c0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_ovf = (w_a[31] == w_bb[31]) & (w_sum[31] != w_a[31]);

  // Output stage FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Output stage FSM: next state. A drain and a new accept in the same cycle
  // keeps the stage FULL, giving one op per cycle under load.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_xfer) w_state_next = ST_FULL;
      ST_FULL: begin
        if (w_xfer) begin
          w_state_next = ST_FULL;
        end else if (rsp_ready) begin
          w_state_next = ST_EMPTY;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  // Output stage FSM: outputs
  always_comb begin
    rsp_valid = (r_state == ST_FULL);
  end

  // Result payload and priority pointer change only on a request transfer.
  // The payload therefore holds its last value after a drain, and stays
  // bit-stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_id   <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_xfer) begin
      r_ptr  <= (w_grant == LAST_ID) ? '0 : w_grant + 1'b1;
      r_id   <= w_grant;
      r_sum  <= w_sum;
      r_cout <= w_cout;
      r_ovf  <= w_ovf;
    end
  end

  assign rsp_id   = r_id;
  assign rsp_sum  = r_sum;
  assign rsp_cout = r_cout;
  assign rsp_ovf  = r_ovf;
endmodule

// File: tb/tb_adder32_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_adder32_rr_sched
//   Self-checking bench for adder32_rr_sched (NREQ=4). Directed scenarios are
//   followed by randomized traffic with random backpressure. Every cycle is
//   compared against a transaction-level reference model: a priority pointer,
//   a one-entry result slot, and arithmetic done with wide signed/unsigned
//   integers.
// -----------------------------------------------------------------------------
module tb_adder32_rr_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_a = '0;
  logic [32*NREQ-1:0]  req_b = '0;
  logic [NREQ-1:0]     req_cin = '0;
  logic [NREQ-1:0]     req_sub = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_sum;
  logic                rsp_cout;
  logic                rsp_ovf;

  adder32_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_ptr;
  logic        m_valid;
  int          m_id;
  logic [31:0] m_sum;
  logic        m_cout;
  logic        m_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_id = 0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
  endtask

  // Arithmetic reference: unsigned 33-bit sum for the carry, subtract carry
  // as "no borrow" (a >= b), overflow as the exact signed result leaving range.
  task automatic ref_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, output logic [31:0] s, output logic co,
                        output logic ov);
    longint sa, sb, st;
    logic [32:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      s  = a - b;
      co = (a >= b);
      st = sa - sb;
    end else begin
      u  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      s  = u[31:0];
      co = u[32];
      st = sa + sb + longint'(cin);
    end
    ov = (st > 64'sd2147483647) || (st < -64'sd2147483648);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 64'(rsp_valid), 64'(m_valid));
    check({tag, "_id"},    64'(rsp_id),    64'(m_id));
    check({tag, "_sum"},   64'(rsp_sum),   64'(m_sum));
    check({tag, "_cout"},  64'(rsp_cout),  64'(m_cout));
    check({tag, "_ovf"},   64'(rsp_ovf),   64'(m_ovf));
  endtask

  // One clock cycle: inputs are already driven. Check req_ready, advance the
  // model, let the edge happen, then check the output stage.
  task automatic cycle(input string tag);
    int g;
    logic can;
    logic [NREQ-1:0] er;
    logic [31:0] s;
    logic co, ov;
    #1;
    can = !m_valid || rsp_ready;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    er = '0;
    if (can && g >= 0) er[g] = 1'b1;
    check({tag, "_ready"}, 64'(req_ready), 64'(er));
    if (can && g >= 0) begin
      ref_op(req_a[32*g +: 32], req_b[32*g +: 32], req_cin[g], req_sub[g], s, co, ov);
      m_valid = 1'b1; m_id = g; m_sum = s; m_cout = co; m_ovf = ov;
      m_ptr = (g + 1) % NREQ;
      $display("xfer %s: id=%0d a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d",
               tag, g, req_a[32*g +: 32], req_b[32*g +: 32], req_cin[g], req_sub[g], s, co, ov);
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_cin[i] = cin;
    req_sub[i] = sub;
  endtask

  // Single-requester operation with the consumer always ready.
  task automatic op1(input string tag, input int i, input logic [31:0] a,
                     input logic [31:0] b, input logic cin, input logic sub);
    set_req(i, a, b, cin, sub);
    req_valid = '0;
    req_valid[i] = 1'b1;
    rsp_ready = 1'b1;
    cycle(tag);
    req_valid = '0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom % 8)
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    model_reset();
    // Reset: outputs zero, req_ready zero even with requests pending.
    req_valid = '1;
    #12;
    check("rst_ready", 64'(req_ready), 64'(0));
    check_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    @(posedge clk);
    #1;

    // Requester 2 alone: 5 + 3 + 1.
    op1("tp1", 2, 32'h5, 32'h3, 1'b1, 1'b0);
    check("tp1_sum_k",  64'(rsp_sum), 64'h9);
    check("tp1_id_k",   64'(rsp_id),  64'd2);

    // Subtracts on requester 0 (cin ignored).
    op1("tp2a", 0, 32'h3, 32'h5, 1'b1, 1'b1);
    check("tp2a_sum_k", 64'(rsp_sum), 64'hFFFF_FFFE);
    op1("tp2b", 0, 32'h8000_0000, 32'h1, 1'b0, 1'b1);
    check("tp2b_sum_k", 64'(rsp_sum), 64'h7FFF_FFFF);
    check("tp2b_ovf_k", 64'(rsp_ovf), 64'd1);
    check("tp2b_cout_k", 64'(rsp_cout), 64'd1);

    // Add boundaries.
    op1("tp3a", 1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    check("tp3a_sum_k", 64'(rsp_sum), 64'h8000_0000);
    check("tp3a_ovf_k", 64'(rsp_ovf), 64'd1);
    op1("tp3b", 3, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    check("tp3b_sum_k", 64'(rsp_sum), 64'h0);
    check("tp3b_cout_k", 64'(rsp_cout), 64'd1);

    // Idle drain cycle, then full load: back-to-back rotating grants.
    rsp_ready = 1'b1;
    cycle("idle");
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h100 * (i + 1), 32'(i), 1'b0, 1'b0);
    req_valid = '1;
    for (int c = 0; c < 8; c++) cycle("full");

    // Backpressure for 3 cycles, then release without a bubble.
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) cycle("bp");
    rsp_ready = 1'b1;
    cycle("bp_rel");

    // Async reset mid-cycle while FULL with ptr=3.
    rsp_ready = 1'b1;
    cycle("drain");
    op1("pre_rst", 2, 32'h11, 32'h22, 1'b0, 1'b0);
    rsp_ready = 1'b0;
    req_valid = '1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_valid", 64'(rsp_valid), 64'd0);
    check("arst_ready", 64'(req_ready), 64'd0);
    check("arst_sum",   64'(rsp_sum),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    cycle("post_rst");
    check("post_rst_id_k", 64'(rsp_id), 64'd0);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        set_req(i, pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
      end
      rsp_ready = (($urandom % 4) != 0);
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adder32_rr_sched.md
Name: adder32_rr_sched

Overview:
- Round-robin scheduler that shares one 32-bit carry-lookahead adder datapath among NREQ requesters.
- Each requester presents an operation over a valid/ready handshake: add with carry-in, or subtract.
- One request is granted per cycle. Its result is registered into a single-entry output stage that carries the requester ID back to the consumer.
- Sits between ALU-style clients and the shared adder32 instance; the adder itself stays purely combinational inside this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID; must equal max(1, clog2(NREQ)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  NREQ  request i valid.
- req_ready  output  NREQ  request i accepted this cycle (one-hot or zero).
- req_a  input  32*NREQ  operand A of requester i at bits [32*i+31:32*i], two's complement.
- req_b  input  32*NREQ  operand B, same packing.
- req_cin  input  NREQ  carry-in for add; ignored for sub.
- req_sub  input  NREQ  1 = A-B, 0 = A+B+cin.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  IDW  index of requester that owns the result.
- rsp_sum  output  32  low 32 bits of the result.
- rsp_cout  output  1  carry out of bit 31 (for sub: 1 = no borrow).
- rsp_ovf  output  1  signed overflow.

Behaviour:
- Reset (asynchronous, any time): rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, priority pointer=0. An in-flight result is discarded. req_ready is combinational and is 0 while rst=1.
- Output stage states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = !rsp_valid | rsp_ready.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, wrapping modulo NREQ.
  - The first set bit is the grant g.
  - req_ready[g]=1 only when can_accept=1; all other req_ready bits are 0.
  - No valid requests, or can_accept=0: req_ready=0.
- Handshake:
  - A request transfers when req_valid[i]&req_ready[i].
  - A response transfers when rsp_valid&rsp_ready.
  - Requesters must hold their operands stable while valid and not ready. The block does not check this.
- Datapath for the granted request:
  - sub=0: bb=b, c0=cin.
  - sub=1: bb=~b, c0=1.
  - {cout,sum} = a + bb + c0, using the 32-bit adder.
  - ovf = (a[31]==bb[31]) & (sum[31]!=a[31]).
- On a request transfer at edge N:
  - rsp_* loads {g, sum, cout, ovf}.
  - rsp_valid=1 after edge N.
  - ptr=(g+1) mod NREQ.
  - Latency is 1 cycle from acceptance to rsp_valid.
- Simultaneous response drain and new accept in the same cycle: the stage reloads and rsp_valid stays 1. Throughput is one op per cycle under full load.
- Drain with no new accept: rsp_valid=0 at the next edge. rsp_id/sum/cout/ovf keep their last values.
- Backpressure (FULL & !rsp_ready): all req_ready=0, ptr unchanged, rsp_* held bit-stable.
- ptr advances only on a transfer. An idle cycle does not rotate priority.
- Fairness: any continuously valid requester is granted within NREQ transfers.
- Bits of req_a/req_b for non-granted requesters have no effect.
- NREQ not a power of two: the wrap skips the nonexistent indices.

Test Plan:
- Reset, then only req_valid[2] with a=0x0000_0005, b=0x0000_0003, cin=1, sub=0, rsp_ready=1 -> req_ready=4'b0100. Next cycle rsp_valid=1, rsp_id=2, rsp_sum=0x9, rsp_cout=0, rsp_ovf=0.
- Requester 0 sub with a=0x0000_0003, b=0x0000_0005, cin=1 -> rsp_sum=0xFFFF_FFFE, rsp_cout=0, rsp_ovf=0. Then a=0x8000_0000, b=0x0000_0001, sub=1 -> rsp_sum=0x7FFF_FFFF, rsp_cout=1, rsp_ovf=1.
- Add a=0x7FFF_FFFF, b=0x1, cin=0 -> rsp_sum=0x8000_0000, rsp_ovf=1, rsp_cout=0. Then a=0xFFFF_FFFF, b=0x1 -> rsp_sum=0, rsp_cout=1, rsp_ovf=0.
- All four requesters held valid, rsp_ready=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3, back-to-back, rsp_valid continuously 1.
- After one result is loaded, rsp_ready=0 for 3 cycles with all requests valid -> req_ready=0 and rsp_* stable for 3 cycles. rsp_ready=1 -> the next grant is ptr's requester in the same cycle, and the output reloads without a bubble.
- Assert rst asynchronously (mid-cycle) while rsp_valid=1 and ptr=3 -> rsp_valid drops immediately. After release, the first grant with all requesters valid goes to requester 0.
